// File: rtl/jtcontra_gfx_pkg.sv
// Shared definitions for the 007121 graphics ROM slot: FSM states and cache geometry.
package jtcontra_gfx_pkg;

    localparam int unsigned NENTRY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/jtcontra_gfx_romslot_if.sv
// Graphics ROM request bus plus SDRAM read handshake seen by one ROM slot.
interface jtcontra_gfx_romslot_if #(
    parameter int AW  = 18,
    parameter int SAW = 22
);
    logic           downloading;
    logic           rom_cs;
    logic [AW-1:0]  rom_addr;
    logic [15:0]    rom_data;
    logic           rom_ok;
    logic           sdram_req;
    logic [SAW-1:0] sdram_addr;
    logic           sdram_ack;
    logic           sdram_dst;
    logic [15:0]    sdram_din;

    // Environment side: graphics chip, SDRAM controller and download logic
    modport master (
        output downloading, rom_cs, rom_addr, sdram_ack, sdram_dst, sdram_din,
        input  rom_data, rom_ok, sdram_req, sdram_addr
    );

    // ROM slot side
    modport slave (
        input  downloading, rom_cs, rom_addr, sdram_ack, sdram_dst, sdram_din,
        output rom_data, rom_ok, sdram_req, sdram_addr
    );

endinterface

// File: rtl/jtcontra_gfx_romslot.sv
// SDRAM-side responder for the 007121 graphics ROM bus.
// Two-entry tagged word cache in flops; misses are fetched over req/ack/dst.
module jtcontra_gfx_romslot
    import jtcontra_gfx_pkg::*;
#(
    parameter int             AW     = 18,
    parameter int             SAW    = 22,
    parameter logic [SAW-1:0] OFFSET = '0
) (
    input  logic                   rst,
    input  logic                   clk,
    jtcontra_gfx_romslot_if.slave  bus
);

    logic [NENTRY-1:0] r_valid;
    logic [AW-1:0]     r_tag  [NENTRY];
    logic [15:0]       r_data [NENTRY];
    logic              r_lru;
    state_t            r_state;
    logic [AW-1:0]     r_pend;
    logic              r_req;
    logic [SAW-1:0]    r_saddr;
    logic              r_ok;
    logic [15:0]       r_rdata;

    logic [NENTRY-1:0] w_hit_vec;
    logic              w_hit;
    logic              w_hit_idx;
    logic [15:0]       w_hit_data;
    logic              w_lookup_ok;
    logic              w_fill;

    // Tag compare against the current address using pre-fill cache contents
    always_comb begin
        w_hit_vec    = '0;
        w_hit_vec[0] = r_valid[0] && (r_tag[0] == bus.rom_addr);
        w_hit_vec[1] = r_valid[1] && (r_tag[1] == bus.rom_addr);
        w_hit        = |w_hit_vec;
        w_hit_idx    = w_hit_vec[1];
        w_hit_data   = r_data[w_hit_idx];
        w_lookup_ok  = bus.rom_cs && w_hit && !bus.downloading;
        w_fill       = (r_state == WAIT) && bus.sdram_dst && !bus.downloading;
    end

    // Cache array and replacement pointer; a fill's LRU flip overrides a same-cycle hit update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_tag   <= '{default: '0};
            r_data  <= '{default: '0};
            r_lru   <= 1'b0;
        end else begin
            if (w_lookup_ok) begin
                r_lru <= ~w_hit_idx;
            end
            if (w_fill) begin
                r_tag[r_lru]   <= r_pend;
                r_data[r_lru]  <= bus.sdram_din;
                r_valid[r_lru] <= 1'b1;
                r_lru          <= ~r_lru;
            end
            if (bus.downloading) begin
                r_valid <= '0;
            end
        end
    end

    // Registered hit response; data holds its last value while ok is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ok    <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ok <= w_lookup_ok;
            if (w_lookup_ok) begin
                r_rdata <= w_hit_data;
            end
        end
    end

    // Miss fetch FSM: an accepted fetch always runs to its data strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_req   <= 1'b0;
            r_saddr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.rom_cs && !w_hit && !bus.downloading) begin
                        r_state <= REQ;
                        r_pend  <= bus.rom_addr;
                        r_req   <= 1'b1;
                        r_saddr <= OFFSET + SAW'(bus.rom_addr);
                    end
                end
                REQ: begin
                    if (bus.sdram_ack) begin
                        r_req   <= 1'b0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.sdram_dst) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_ok     = r_ok;
    assign bus.rom_data   = r_rdata;
    assign bus.sdram_req  = r_req;
    assign bus.sdram_addr = r_saddr;

endmodule
